// File: rtl/btn_irq_pkg.sv
// Shared types and helpers for the push-button interrupt source.
package btn_irq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_FALL = 2'b01,
        MODE_RISE = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic edge_hit(
        input edge_mode_e m,
        input logic       rise,
        input logic       fall
    );
        logic hit;
        hit = 1'b0;
        unique case (m)
            MODE_OFF:  hit = 1'b0;
            MODE_FALL: hit = fall;
            MODE_RISE: hit = rise;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, stable-count debouncer and
// registered rise/fall pulses aligned with the debounced toggle.
module btn_debounce #(
    parameter int   DEB_CYCLES = 16,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             mismatch;

    assign mismatch = sync_q[1] ^ level_q;
    assign o_level  = level_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q  <= {2{IDLE_LEVEL}};
            cnt_q   <= '0;
            level_q <= IDLE_LEVEL;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_btn};
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            if (!mismatch) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // Accept the new level; pulse reflects the direction taken
                level_q <= ~level_q;
                cnt_q   <= '0;
                o_rise  <= ~level_q;
                o_fall  <= level_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_irq_ctrl.sv
// Push-button interrupt source: per-channel debounce, pending latch,
// mask, lowest-index priority and registered request to the core.
module btn_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int   N_CH       = 4,
    parameter int   DEB_CYCLES = 16,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   ID_W       = id_width(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_btn,
    input  logic [2*N_CH-1:0] i_mode,
    input  logic [N_CH-1:0]   i_mask_en,
    input  logic              i_ack,
    input  logic [ID_W-1:0]   i_ack_id,
    output logic              o_irq,
    output logic [ID_W-1:0]   o_irq_id,
    output logic [N_CH-1:0]   o_pending,
    output logic [N_CH-1:0]   o_btn_level
);

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] set_vec;
    logic [N_CH-1:0] ack_vec;
    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] req;
    logic [ID_W-1:0] enc;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .IDLE_LEVEL (IDLE_LEVEL)
        ) u_deb (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_btn   (i_btn[k]),
            .o_level (o_btn_level[k]),
            .o_rise  (rise[k]),
            .o_fall  (fall[k])
        );

        assign set_vec[k] = edge_hit(edge_mode_e'(i_mode[2*k +: 2]),
                                     rise[k], fall[k]);
    end

    // Out-of-range ids simply match no channel
    always_comb begin
        ack_vec = '0;
        for (int k = 0; k < N_CH; k++) begin
            ack_vec[k] = i_ack && (int'(i_ack_id) == k);
        end
    end

    assign req = pend_q & i_mask_en;

    always_comb begin
        enc = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (req[k]) enc = ID_W'(k);
        end
    end

    // New events take precedence over a same-cycle claim
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_q   <= '0;
            o_irq    <= 1'b0;
            o_irq_id <= '0;
        end else begin
            pend_q <= (pend_q & ~ack_vec) | set_vec;
            o_irq  <= |req;
            if (|req) o_irq_id <= enc;
        end
    end

    assign o_pending = pend_q;

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Directed plus random bench for btn_irq_ctrl against a window-rule
// reference model of debounce, pending, mask and priority.
module tb_btn_irq_ctrl;

    localparam int N   = 4;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn;
    logic [7:0] mode;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_id;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] pend;
    logic [3:0] lvl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    btn_irq_ctrl #(
        .N_CH       (N),
        .DEB_CYCLES (DEB),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn       (btn),
        .i_mode      (mode),
        .i_mask_en   (mask),
        .i_ack       (ack),
        .i_ack_id    (ack_id),
        .o_irq       (irq),
        .o_irq_id    (irq_id),
        .o_pending   (pend),
        .o_btn_level (lvl)
    );

    // Reference model: a level is accepted once the last DEB synchronised
    // samples (raw input delayed by two edges) all differ from it.
    logic [3:0] m_lvl, m_pend, m_rise, m_fall, m_req, w;
    logic       m_irq, all_diff, hit;
    logic [1:0] m_id, md;
    logic [3:0] hist[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lvl  = 4'hF;
            m_pend = '0;
            m_rise = '0;
            m_fall = '0;
            m_irq  = 1'b0;
            m_id   = '0;
            hist.delete();
            for (int i = 0; i < DEB + 1; i++) hist.push_back(4'hF);
        end else begin
            m_req = m_pend & mask;
            m_irq = |m_req;
            for (int k = N - 1; k >= 0; k--) begin
                if (m_req[k]) m_id = 2'(k);
            end
            for (int k = 0; k < N; k++) begin
                md  = mode[2*k +: 2];
                hit = (md == 2'b01 && m_fall[k]) ||
                      (md == 2'b10 && m_rise[k]) ||
                      (md == 2'b11 && (m_rise[k] || m_fall[k]));
                if (ack && int'(ack_id) == k) m_pend[k] = 1'b0;
                if (hit) m_pend[k] = 1'b1;
            end
            hist.push_back(btn);
            m_rise = '0;
            m_fall = '0;
            for (int k = 0; k < N; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    w = hist[j];
                    if (w[k] == m_lvl[k]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_rise[k] = ~m_lvl[k];
                    m_fall[k] = m_lvl[k];
                    m_lvl[k]  = ~m_lvl[k];
                end
            end
            void'(hist.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("m_lvl", 32'(lvl), 32'(m_lvl));
        chk("m_pend", 32'(pend), 32'(m_pend));
        chk("m_irq", 32'(irq), 32'(m_irq));
        chk("m_id", 32'(irq_id), 32'(m_id));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            chk_model();
        end
    endtask

    initial begin
        int b;
        btn    = 4'hF;
        mode   = 8'h55;
        mask   = 4'hF;
        ack    = 1'b0;
        ack_id = '0;
        repeat (2) @(negedge clk);
        chk("rst_lvl", 32'(lvl), 32'hF);
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_id", 32'(irq_id), 32'h0);
        rst = 1'b0;

        step(50);
        chk("idle_lvl", 32'(lvl), 32'hF);
        chk("idle_pend", 32'(pend), 32'h0);
        chk("idle_irq", 32'(irq), 32'h0);

        // Press latency on ch0
        btn = 4'hE;
        step(5);
        chk("lat_lvl5", 32'(lvl), 32'hF);
        step(1);
        chk("lat_lvl6", 32'(lvl), 32'hE);
        chk("lat_pend6", 32'(pend), 32'h0);
        step(1);
        chk("lat_pend7", 32'(pend), 32'h1);
        chk("lat_irq7", 32'(irq), 32'h0);
        step(1);
        chk("lat_irq8", 32'(irq), 32'h1);
        chk("lat_id8", 32'(irq_id), 32'h0);

        // Short glitch on ch1
        btn = 4'hC;
        step(3);
        btn = 4'hE;
        step(12);
        chk("glitch_lvl", 32'(lvl), 32'hE);
        chk("glitch_pend", 32'(pend), 32'h1);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2 rst = 1'b1;
        btn = 4'hF;
        #1;
        chk("arst_lvl", 32'(lvl), 32'hF);
        chk("arst_pend", 32'(pend), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(10);
        chk("arst_quiet", 32'(pend), 32'h0);

        // Priority and claim
        btn = 4'h9;
        step(8);
        chk("pri_pend", 32'(pend), 32'h6);
        chk("pri_irq", 32'(irq), 32'h1);
        chk("pri_id1", 32'(irq_id), 32'h1);
        ack = 1'b1;
        ack_id = 2'd1;
        step(1);
        ack = 1'b0;
        chk("clm_pend", 32'(pend), 32'h4);
        chk("clm_id_hold", 32'(irq_id), 32'h1);
        step(1);
        chk("clm_id2", 32'(irq_id), 32'h2);
        ack = 1'b1;
        ack_id = 2'd2;
        step(1);
        ack = 1'b0;
        step(1);
        chk("clm_irq0", 32'(irq), 32'h0);
        chk("clm_pend0", 32'(pend), 32'h0);
        btn = 4'hF;
        step(10);

        // Modes: ch3 rise, ch2 fall, ch1 off, ch0 both
        mode = 8'h93;
        btn = 4'h0;
        step(8);
        chk("mode_press", 32'(pend), 32'h5);
        btn = 4'hF;
        step(8);
        chk("mode_rel", 32'(pend), 32'hD);
        for (int k = 0; k < 4; k++) begin
            if (k != 1) begin
                ack = 1'b1;
                ack_id = 2'(k);
                step(1);
                ack = 1'b0;
            end
        end
        step(2);
        chk("mode_clr", 32'(pend), 32'h0);
        chk("mode_irq", 32'(irq), 32'h0);

        // Mask gates only the request
        mode = 8'h55;
        mask = 4'h0;
        btn = 4'hE;
        step(8);
        chk("mask_pend", 32'(pend), 32'h1);
        chk("mask_irq", 32'(irq), 32'h0);
        mask = 4'h1;
        step(1);
        chk("unmask_irq", 32'(irq), 32'h1);
        chk("unmask_id", 32'(irq_id), 32'h0);

        // Claim lands with a new ch0 event
        mode = 8'h57;
        btn = 4'hF;
        step(6);
        ack = 1'b1;
        ack_id = 2'd0;
        step(1);
        ack = 1'b0;
        chk("set_wins", 32'(pend), 32'h1);
        ack = 1'b1;
        ack_id = 2'd1;
        step(1);
        ack = 1'b0;
        step(1);
        chk("ack_idle_pend", 32'(pend), 32'h1);
        chk("ack_idle_irq", 32'(irq), 32'h1);
        ack = 1'b1;
        ack_id = 2'd0;
        step(1);
        ack = 1'b0;
        step(1);
        chk("ack_final", 32'(irq), 32'h0);

        // Random traffic against the model
        mask = 4'hF;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) begin
                b = int'($urandom_range(3));
                btn[b] = ~btn[b];
            end
            if ($urandom_range(63) == 0) mode = 8'($urandom);
            if ($urandom_range(31) == 0) mask = 4'($urandom);
            ack = ($urandom_range(3) == 0);
            ack_id = ($urandom_range(1) == 0) ? m_id : 2'($urandom);
            step(1);
        end
        ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
